// File: rtl/ras_pkg.sv
// Shared sizing, pointer-pair type and reset constants for the return
// address stack and its speculation checkpoints.
package ras_pkg;

  localparam int RAS_DEPTH  = 4;
  localparam int CKPT_DEPTH = 4;
  localparam int PW         = $clog2(RAS_DEPTH);
  localparam int TW         = $clog2(CKPT_DEPTH);

  typedef struct packed {
    logic [PW-1:0] tosp;
    logic [PW:0]   depth;
  } ras_ptr_t;

  localparam logic [PW-1:0] TOSP_RST   = PW'(RAS_DEPTH - 1);
  localparam logic [PW-1:0] TOSP_ONE   = PW'(1);
  localparam logic [PW:0]   DEPTH_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   DEPTH_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   DEPTH_MAX  = (PW+1)'(RAS_DEPTH);
  localparam ras_ptr_t      PTR_RST    = '{tosp: TOSP_RST, depth: DEPTH_ZERO};

  localparam logic [TW-1:0] TAG_ZERO   = TW'(0);
  localparam logic [TW-1:0] TAG_ONE    = TW'(1);
  localparam logic [TW:0]   CNT_ZERO   = (TW+1)'(0);
  localparam logic [TW:0]   CNT_ONE    = (TW+1)'(1);
  localparam logic [TW:0]   CNT_FULL   = (TW+1)'(CKPT_DEPTH);

endpackage

// File: rtl/ras_ptr_shadow.sv
// TOSP/depth pointer pair with push, pop and load; shared with the RAS
// pointer logic so both copies follow identical update rules.
module ras_ptr_shadow
  import ras_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  logic     load,
  input  ras_ptr_t load_val,
  output ras_ptr_t ptr
);

  ras_ptr_t ptr_r;
  ras_ptr_t ptr_nxt_s;

  // Next pointer pair: a load overrides any push or pop in the same cycle.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (load) begin
      ptr_nxt_s = load_val;
    end else if (push && !pop) begin
      ptr_nxt_s.tosp = ptr_r.tosp + TOSP_ONE;
      if (ptr_r.depth != DEPTH_MAX) begin
        ptr_nxt_s.depth = ptr_r.depth + DEPTH_ONE;
      end else begin
        ptr_nxt_s.depth = ptr_r.depth;
      end
    end else if (pop && !push) begin
      if (ptr_r.depth != DEPTH_ZERO) begin
        ptr_nxt_s.tosp  = ptr_r.tosp - TOSP_ONE;
        ptr_nxt_s.depth = ptr_r.depth - DEPTH_ONE;
      end else begin
        ptr_nxt_s = ptr_r;
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= PTR_RST;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/ras_ckpt_ctrl.sv
// RAS speculation controller: snapshots the shadow RAS pointers per
// conditional branch and restores them into the RAS on a mispredict.
module ras_ckpt_ctrl
  import ras_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          du_jal_push,
  input  logic          du_jr31_pop,
  input  logic          du_br_dispatch,
  output logic [TW-1:0] ckpt_tag,
  output logic          ckpt_full,
  input  logic          rob_br_commit,
  input  logic          br_mispredict,
  input  logic [TW-1:0] br_mispredict_tag,
  output logic          ras_restore,
  output logic [PW-1:0] ras_restore_tosp,
  output logic [PW:0]   ras_restore_depth,
  output logic          ckpt_err
);

  logic [TW-1:0] head_r;
  logic [TW-1:0] tail_r;
  logic [TW:0]   count_r;
  ras_ptr_t      slot_r [CKPT_DEPTH];
  logic          restore_r;
  ras_ptr_t      restore_ptr_r;
  logic          err_r;

  ras_ptr_t      shadow_s;
  ras_ptr_t      mp_slot_s;
  logic          multi_s;
  logic [TW-1:0] mp_off_s;
  logic          mp_ok_s;
  logic          mp_bad_s;
  logic          full_s;
  logic          empty_s;
  logic          alloc_s;
  logic          alloc_err_s;
  logic          push_s;
  logic          pop_s;
  logic          commit_ok_s;
  logic          commit_err_s;
  logic [TW-1:0] head_nxt_s;
  logic [TW-1:0] tail_nxt_s;
  logic [TW:0]   count_nxt_s;

  // Request decode: a valid mispredict squashes every dispatch-side action.
  always_comb begin
    multi_s      = (du_jal_push && du_jr31_pop) ||
                   (du_jal_push && du_br_dispatch) ||
                   (du_jr31_pop && du_br_dispatch);
    mp_off_s     = br_mispredict_tag - head_r;
    mp_ok_s      = br_mispredict && ({1'b0, mp_off_s} < count_r);
    mp_bad_s     = br_mispredict && !({1'b0, mp_off_s} < count_r);
    mp_slot_s    = slot_r[br_mispredict_tag];
    full_s       = (count_r == CNT_FULL);
    empty_s      = (count_r == CNT_ZERO);
    alloc_s      = du_br_dispatch && !multi_s && !mp_ok_s && !full_s;
    alloc_err_s  = du_br_dispatch && !multi_s && !mp_ok_s && full_s;
    push_s       = du_jal_push && !multi_s && !mp_ok_s;
    pop_s        = du_jr31_pop && !multi_s && !mp_ok_s;
    commit_ok_s  = rob_br_commit && (mp_ok_s || !empty_s);
    commit_err_s = rob_br_commit && !mp_ok_s && empty_s;
  end

  // Queue pointers; a commit is applied after any mispredict truncation.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (mp_ok_s) begin
      tail_nxt_s  = br_mispredict_tag + TAG_ONE;
      count_nxt_s = {1'b0, mp_off_s} + CNT_ONE;
    end else if (alloc_s) begin
      tail_nxt_s  = tail_r + TAG_ONE;
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      tail_nxt_s  = tail_r;
      count_nxt_s = count_r;
    end
    if (commit_ok_s) begin
      head_nxt_s  = head_r + TAG_ONE;
      count_nxt_s = count_nxt_s - CNT_ONE;
    end else begin
      head_nxt_s  = head_r;
    end
  end

  ras_ptr_shadow u_shadow (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .load     (mp_ok_s),
    .load_val (mp_slot_s),
    .ptr      (shadow_s)
  );

  // Checkpoint queue, restore pulse and sticky error state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r        <= TAG_ZERO;
      tail_r        <= TAG_ZERO;
      count_r       <= CNT_ZERO;
      restore_r     <= 1'b0;
      restore_ptr_r <= '{tosp: {PW{1'b0}}, depth: DEPTH_ZERO};
      err_r         <= 1'b0;
      for (int i = 0; i < CKPT_DEPTH; i++) begin
        slot_r[i] <= PTR_RST;
      end
    end else begin
      head_r    <= head_nxt_s;
      tail_r    <= tail_nxt_s;
      count_r   <= count_nxt_s;
      restore_r <= mp_ok_s;
      err_r     <= err_r || multi_s || mp_bad_s || alloc_err_s || commit_err_s;
      if (mp_ok_s) begin
        restore_ptr_r <= mp_slot_s;
      end else begin
        restore_ptr_r <= restore_ptr_r;
      end
      if (alloc_s) begin
        slot_r[tail_r] <= shadow_s;
      end else begin
        slot_r[tail_r] <= slot_r[tail_r];
      end
    end
  end

  assign ckpt_tag          = tail_r;
  assign ckpt_full         = full_s;
  assign ras_restore       = restore_r;
  assign ras_restore_tosp  = restore_ptr_r.tosp;
  assign ras_restore_depth = restore_ptr_r.depth;
  assign ckpt_err          = err_r;

endmodule

// File: doc/ras_ckpt_ctrl.md
Name: ras_ckpt_ctrl

Overview:
- Speculation controller for the 4-entry return address stack (RAS).
- Keeps a shadow copy of the RAS pointer state (TOSP, depth) and takes a snapshot of that state when the dispatch unit dispatches each conditional branch.
- On a branch mispredict, drives the saved pointer state back into the RAS and frees the checkpoints of all younger branches.
- Sits between the dispatch unit, the branch resolution path and the RAS pointer logic.

Parameters:
- RAS_DEPTH, 4, entries in the RAS. Must be a power of two.
- CKPT_DEPTH, 4, number of checkpoint slots, which is also the number of branch tags in flight. Must be a power of two.
- PW, $clog2(RAS_DEPTH), width of TOSP.
- TW, $clog2(CKPT_DEPTH), width of a branch tag.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- du_jal_push  in  1  JAL dispatched this cycle; RAS push.
- du_jr31_pop  in  1  JR $31 dispatched this cycle; RAS pop.
- du_br_dispatch  in  1  conditional branch dispatched this cycle; allocate a checkpoint.
- ckpt_tag  out  TW  tag given to the branch dispatched this cycle (current tail index).
- ckpt_full  out  1  no free checkpoint slot; dispatch unit must stall branches.
- rob_br_commit  in  1  the oldest branch graduated; free the head checkpoint.
- br_mispredict  in  1  a branch resolved as mispredicted.
- br_mispredict_tag  in  TW  tag of the mispredicted branch.
- ras_restore  out  1  one-cycle pulse: RAS loads the restore values below.
- ras_restore_tosp  out  PW  TOSP value to restore.
- ras_restore_depth  out  PW+1  depth value to restore.
- ckpt_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, active-high):
  - shadow tosp = RAS_DEPTH-1, shadow depth = 0;
  - head = tail = 0, count = 0;
  - ras_restore = 0, ras_restore_tosp = 0, ras_restore_depth = 0, ckpt_err = 0;
  - ckpt_full = 0, ckpt_tag = 0.
  - Reset asserted in the middle of a restore cancels the pulse immediately.
- Shadow pointer updates (registered, same rules as the RAS):
  - push: tosp+1 modulo RAS_DEPTH; depth+1, saturating at RAS_DEPTH.
  - pop: only when depth != 0, tosp-1 modulo RAS_DEPTH and depth-1. A pop with depth 0 changes nothing.
  - du_jal_push, du_jr31_pop and du_br_dispatch are mutually exclusive (one dispatch per cycle). Two or more asserted together sets ckpt_err, and the cycle is treated as idle.
- Checkpoint allocation:
  - On du_br_dispatch with count < CKPT_DEPTH: slot[tail] <= {tosp, depth} as they are now (pre-edge), tail+1, count+1.
  - ckpt_tag = tail (combinational).
  - ckpt_full = (count == CKPT_DEPTH) (combinational).
  - Dispatch while full is ignored and sets ckpt_err.
- Commit:
  - rob_br_commit with count != 0: head+1, count-1.
  - Commit with count 0 sets ckpt_err.
  - A same-cycle commit and allocate are both applied, so count is unchanged.
- Mispredict (priority over everything else in the same cycle):
  - Squash any same-cycle push, pop or allocate; they have no effect.
  - Shadow {tosp, depth} <= slot[t], where t = br_mispredict_tag.
  - tail <= t+1. count <= (t - head) mod CKPT_DEPTH, plus 1.
  - A same-cycle commit is applied after truncation: if t == head, that commit frees the slot, so count = 0 and head = t+1.
  - On the next edge: ras_restore = 1 for exactly one cycle, ras_restore_tosp and ras_restore_depth = slot[t]. Restore latency is 1 cycle.
  - A tag outside [head, tail) (an empty slot) sets ckpt_err and is otherwise ignored.
- During the cycle in which ras_restore is high, the shadow state already holds the restored values. Pushes and pops in that cycle apply on top of the restored values.
- Wrap-around: head, tail and TOSP are all modulo counters. count is TW+1 bits wide so that full and empty can be told apart.

Decomposition:
- Shared package ras_pkg holds:
  - RAS_DEPTH, CKPT_DEPTH and the derived widths;
  - the typedef ras_ptr_t {tosp, depth};
  - the TOSP reset constant (RAS_DEPTH-1).
- Sub-module ras_ptr_shadow: the shadow tosp/depth register with push, pop and load inputs. The RAS's own pointer logic reuses it.

Test Plan:
- Reset, then 3 pushes, then a branch dispatch → ckpt_tag = 0, slot0 = {tosp = 2, depth = 3}, count = 1, ckpt_full = 0.
- Dispatch 4 branches with no commits → ckpt_full = 1 after the 4th. A 5th dispatch → ckpt_err = 1 and tail unchanged (0).
- From {tosp = 2, depth = 3}: branch (tag 0), then 2 pops, then branch (tag 1), then mispredict tag 0 → one cycle later ras_restore = 1, tosp = 2, depth = 3; tail = 1, count = 1.
- Push 5 times from reset, then checkpoint → snapshot has depth = 4 (saturated) and tosp = 0 (wrapped).
- Same-cycle mispredict (tag 1) and du_jal_push → push squashed. Shadow equals slot1, and the restore pulse follows 1 cycle later.
- Assert reset in the cycle ras_restore is high → ras_restore drops immediately; shadow returns to tosp = 3, depth = 0.
